// File: rtl/fake_differential_rx.sv
// Pseudo-differential receiver: per-leg synchronizers, run-length glitch filter,
// and an ACQUIRE/LOCKED/FAULT tracker with a saturating fault-event counter.
module fake_differential_rx #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 3,
  parameter int unsigned FAULT_LIMIT = 4,
  parameter int unsigned ERR_WIDTH   = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_data_p,
  input  logic                 i_data_n,
  input  logic                 i_clear_err,
  output logic                 o_data,
  output logic                 o_valid,
  output logic                 o_fault,
  output logic [ERR_WIDTH-1:0] o_err_count
);

  localparam int unsigned RUN_W = $clog2(FILTER_LEN + 1);
  localparam int unsigned INV_W = $clog2(FAULT_LIMIT + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(FILTER_LEN);
  localparam logic [INV_W-1:0] INV_MAX = INV_W'(FAULT_LIMIT);

  typedef enum logic [1:0] {
    ST_ACQUIRE = 2'd0,
    ST_LOCKED  = 2'd1,
    ST_FAULT   = 2'd2
  } state_e;

  logic [SYNC_STAGES-1:0] p_sync_q, p_sync_d;
  logic [SYNC_STAGES-1:0] n_sync_q, n_sync_d;
  logic                   cand_q, cand_d;
  logic [RUN_W-1:0]       run_q, run_d;
  logic [INV_W-1:0]       inv_q, inv_d;
  state_e                 state_q, state_d;
  logic                   data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   fault_q, fault_d;
  logic [ERR_WIDTH-1:0]   err_q, err_d;

  logic smp_p, smp_n, smp_valid, accept, fault_entry;

  // Filter, invalid-run tracking and state transitions for one consumed sample
  always_comb begin
    p_sync_d    = {p_sync_q[SYNC_STAGES-2:0], i_data_p};
    n_sync_d    = {n_sync_q[SYNC_STAGES-2:0], i_data_n};
    cand_d      = cand_q;
    run_d       = run_q;
    inv_d       = inv_q;
    state_d     = state_q;
    data_d      = data_q;
    err_d       = err_q;
    accept      = 1'b0;
    fault_entry = 1'b0;

    smp_p     = p_sync_q[SYNC_STAGES-1];
    smp_n     = n_sync_q[SYNC_STAGES-1];
    smp_valid = smp_p ^ smp_n;

    if (smp_valid) begin
      inv_d = '0;
      if (smp_p != cand_q) begin
        cand_d = smp_p;
        run_d  = RUN_W'(1);
      end else if (run_q != RUN_MAX) begin
        run_d = run_q + RUN_W'(1);
      end
      // A reload to a full run (FILTER_LEN == 1) still counts as reaching the limit
      accept = (run_d == RUN_MAX) && ((run_q != RUN_MAX) || (cand_d != cand_q));
    end else begin
      run_d = '0;
      if (inv_q != INV_MAX) begin
        inv_d = inv_q + INV_W'(1);
      end
      fault_entry = (inv_d == INV_MAX) && (inv_q != INV_MAX) && (state_q != ST_FAULT);
    end

    if (accept) begin
      data_d = cand_d;
    end

    case (state_q)
      ST_ACQUIRE: begin
        if (fault_entry) begin
          state_d = ST_FAULT;
        end else if (accept) begin
          state_d = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (fault_entry) begin
          state_d = ST_FAULT;
        end
      end
      ST_FAULT: begin
        if (smp_valid) begin
          state_d = accept ? ST_LOCKED : ST_ACQUIRE;
        end
      end
      default: state_d = ST_ACQUIRE;
    endcase

    valid_d = (state_d == ST_LOCKED);
    fault_d = (state_d == ST_FAULT);

    // Clear wins over a coincident fault entry
    if (i_clear_err) begin
      err_d = '0;
    end else if (fault_entry && (err_q != {ERR_WIDTH{1'b1}})) begin
      err_d = err_q + ERR_WIDTH'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      p_sync_q <= '0;
      n_sync_q <= '0;
      cand_q   <= 1'b0;
      run_q    <= '0;
      inv_q    <= '0;
      state_q  <= ST_ACQUIRE;
      data_q   <= 1'b0;
      valid_q  <= 1'b0;
      fault_q  <= 1'b0;
      err_q    <= '0;
    end else begin
      p_sync_q <= p_sync_d;
      n_sync_q <= n_sync_d;
      cand_q   <= cand_d;
      run_q    <= run_d;
      inv_q    <= inv_d;
      state_q  <= state_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      fault_q  <= fault_d;
      err_q    <= err_d;
    end
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_fault     = fault_q;
  assign o_err_count = err_q;

endmodule

// File: tb/tb_fake_differential_rx.sv
// Bench for fake_differential_rx: directed scenarios plus random pin activity,
// checked against a sample-history model on a default and a 2-bit-counter instance.
module tb_fake_differential_rx;

  localparam int unsigned SS   = 2;
  localparam int unsigned FL   = 3;
  localparam int unsigned FLIM = 4;
  localparam int unsigned EW   = 16;
  localparam int unsigned EW2  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic dp = 1'b0;
  logic dn = 1'b0;
  logic clr = 1'b0;

  logic          data_a, valid_a, fault_a;
  logic [EW-1:0] err_a;
  logic          data_b, valid_b, fault_b;
  logic [EW2-1:0] err_b;

  int total = 0;
  int passed = 0;
  int fails = 0;

  bit mq_p[$];
  bit mq_n[$];
  int m_cand, m_run, m_inv, m_state, m_data, m_err_a, m_err_b;

  always #5 clk = ~clk;

  fake_differential_rx #(.SYNC_STAGES(SS), .FILTER_LEN(FL), .FAULT_LIMIT(FLIM), .ERR_WIDTH(EW)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_data_p(dp), .i_data_n(dn), .i_clear_err(clr),
    .o_data(data_a), .o_valid(valid_a), .o_fault(fault_a), .o_err_count(err_a)
  );

  fake_differential_rx #(.SYNC_STAGES(SS), .FILTER_LEN(FL), .FAULT_LIMIT(FLIM), .ERR_WIDTH(EW2)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_data_p(dp), .i_data_n(dn), .i_clear_err(clr),
    .o_data(data_b), .o_valid(valid_b), .o_fault(fault_b), .o_err_count(err_b)
  );

  task automatic model_reset();
    mq_p.delete();
    mq_n.delete();
    for (int i = 0; i < int'(SS); i++) begin
      mq_p.push_back(1'b0);
      mq_n.push_back(1'b0);
    end
    m_cand = 0; m_run = 0; m_inv = 0; m_state = 0; m_data = 0; m_err_a = 0; m_err_b = 0;
  endtask

  // Model state: 0 = acquiring, 1 = locked, 2 = fault
  task automatic model_edge();
    bit sp, sn, loaded, accept, entry;
    int prev;
    loaded = 1'b0; accept = 1'b0; entry = 1'b0;
    if (!rst_n) begin
      model_reset();
      return;
    end
    sp = mq_p.pop_front();
    sn = mq_n.pop_front();
    mq_p.push_back(dp);
    mq_n.push_back(dn);
    if (sp != sn) begin
      m_inv = 0;
      prev = m_run;
      if (int'(sp) != m_cand) begin
        m_cand = int'(sp); m_run = 1; loaded = 1'b1;
      end else if (m_run < int'(FL)) begin
        m_run++;
      end
      accept = (m_run == int'(FL)) && (prev != int'(FL) || loaded);
      if (accept) m_data = m_cand;
      if (m_state == 2) m_state = accept ? 1 : 0;
      else if (m_state == 0 && accept) m_state = 1;
    end else begin
      m_run = 0;
      entry = (m_inv == int'(FLIM) - 1);
      if (m_inv < int'(FLIM)) m_inv++;
      if (entry) m_state = 2;
    end
    if (clr) begin
      m_err_a = 0; m_err_b = 0;
    end else if (entry) begin
      if (m_err_a < (1 << EW) - 1) m_err_a++;
      if (m_err_b < (1 << EW2) - 1) m_err_b++;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".data_a"},  32'(data_a),  32'(m_data));
    chk({tag, ".valid_a"}, 32'(valid_a), 32'(m_state == 1));
    chk({tag, ".fault_a"}, 32'(fault_a), 32'(m_state == 2));
    chk({tag, ".err_a"},   32'(err_a),   32'(m_err_a));
    chk({tag, ".data_b"},  32'(data_b),  32'(m_data));
    chk({tag, ".valid_b"}, 32'(valid_b), 32'(m_state == 1));
    chk({tag, ".fault_b"}, 32'(fault_b), 32'(m_state == 2));
    chk({tag, ".err_b"},   32'(err_b),   32'(m_err_b));
  endtask

  task automatic step(input string tag, input logic p, input logic n, input logic c);
    @(negedge clk);
    dp = p; dn = n; clr = c;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    int hold;
    logic rp, rn, rc;

    model_reset();
    #1;
    check_all("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // First lock: o_valid rises exactly on edge 5
    repeat (4) step("r031", 1'b1, 1'b0, 1'b0);
    chk("r031.valid_before", 32'(valid_a), 32'd0);
    step("r031", 1'b1, 1'b0, 1'b0);
    chk("r031.data_e5",  32'(data_a),  32'd1);
    chk("r031.valid_e5", 32'(valid_a), 32'd1);
    chk("r031.fault_e5", 32'(fault_a), 32'd0);
    chk("r031.err_e5",   32'(err_a),   32'd0);
    repeat (3) step("r031.hold", 1'b1, 1'b0, 1'b0);

    // Short opposite glitch is filtered out
    repeat (2) step("r032", 1'b0, 1'b1, 1'b0);
    repeat (6) step("r032", 1'b1, 1'b0, 1'b0);
    chk("r032.data",  32'(data_a),  32'd1);
    chk("r032.valid", 32'(valid_a), 32'd1);

    // Three invalid samples: no fault
    repeat (3) step("r033a", 1'b1, 1'b1, 1'b0);
    repeat (6) step("r033a", 1'b1, 1'b0, 1'b0);
    chk("r033a.fault", 32'(fault_a), 32'd0);
    chk("r033a.valid", 32'(valid_a), 32'd1);

    // Four invalid samples: fault, then recovery to 0
    repeat (4) step("r033b", 1'b1, 1'b1, 1'b0);
    step("r033b", 1'b0, 1'b1, 1'b0);
    chk("r033b.fault_pre", 32'(fault_a), 32'd0);
    step("r033b", 1'b0, 1'b1, 1'b0);
    chk("r033b.fault", 32'(fault_a), 32'd1);
    chk("r033b.valid", 32'(valid_a), 32'd0);
    chk("r033b.data",  32'(data_a),  32'd1);
    chk("r033b.err",   32'(err_a),   32'd1);
    step("r033b", 1'b0, 1'b1, 1'b0);
    chk("r033b.fault_exit", 32'(fault_a), 32'd0);
    step("r033b", 1'b0, 1'b1, 1'b0);
    chk("r033b.data_hold", 32'(data_a), 32'd1);
    step("r033b", 1'b0, 1'b1, 1'b0);
    chk("r033b.data_new",  32'(data_a),  32'd0);
    chk("r033b.valid_new", 32'(valid_a), 32'd1);

    // Clear coincident with fault entry
    repeat (3) step("r034", 1'b0, 1'b1, 1'b0);
    repeat (4) step("r034", 1'b1, 1'b1, 1'b0);
    step("r034", 1'b0, 1'b1, 1'b0);
    step("r034", 1'b0, 1'b1, 1'b1);
    chk("r034.fault", 32'(fault_a), 32'd1);
    chk("r034.err_a", 32'(err_a),   32'd0);
    chk("r034.err_b", 32'(err_b),   32'd0);
    repeat (5) step("r034", 1'b0, 1'b1, 1'b0);

    // Five fault entries saturate the 2-bit counter
    for (int k = 0; k < 5; k++) begin
      repeat (6) step("r035", 1'b1, 1'b0, 1'b0);
      repeat (6) step("r035", 1'b1, 1'b1, 1'b0);
    end
    chk("r035.err_b", 32'(err_b), 32'd3);
    chk("r035.err_a", 32'(err_a), 32'd5);
    repeat (6) step("r035", 1'b1, 1'b0, 1'b0);

    // Random pin activity with occasional clears
    for (int it = 0; it < 400; it++) begin
      hold = int'($urandom_range(1, 7));
      rp = 1'($urandom);
      rn = ($urandom_range(0, 3) == 0) ? rp : ~rp;
      for (int h = 0; h < hold; h++) begin
        rc = ($urandom_range(0, 15) == 0);
        step("rand", rp, rn, rc);
      end
    end

    // Asynchronous reset between edges while locked
    repeat (8) step("r036", 1'b1, 1'b0, 1'b0);
    chk("r036.locked", 32'(valid_a), 32'd1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("r036.data",  32'(data_a),  32'd0);
    chk("r036.valid", 32'(valid_a), 32'd0);
    chk("r036.fault", 32'(fault_a), 32'd0);
    chk("r036.err",   32'(err_a),   32'd0);
    model_reset();
    repeat (2) step("r036.inrst", 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) step("r036.after", 1'b0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
